// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - MemOp codes, FSM encoding and lane/byte-enable helpers for the MEM stage
package mem_pkg;

  localparam logic [2:0] MEMOP_W  = 3'b000;
  localparam logic [2:0] MEMOP_HU = 3'b001;
  localparam logic [2:0] MEMOP_H  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b011;
  localparam logic [2:0] MEMOP_B  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  // Unassigned MemOp codes fall back to word accesses.
  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      MEMOP_HU, MEMOP_H: return SZ_HALF;
      MEMOP_BU, MEMOP_B: return SZ_BYTE;
      default:           return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lane);
    case (op_size(op))
      SZ_HALF: return ~lane[0];
      SZ_BYTE: return 1'b1;
      default: return (lane == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] lane);
    case (op_size(op))
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] wdata);
    case (op_size(op))
      SZ_HALF: return {2{wdata[15:0]}};
      SZ_BYTE: return {4{wdata[7:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extender.sv
// rtl/mem_access_stage_load_extender.sv - lane select and zero/sign extension of load data
module load_extender
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] ext
);

  logic [15:0] half;
  logic [7:0]  byt;

  always_comb begin
    half = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lane)
      2'd0:    byt = rdata[7:0];
      2'd1:    byt = rdata[15:8];
      2'd2:    byt = rdata[23:16];
      default: byt = rdata[31:24];
    endcase
    case (op_size(op))
      SZ_HALF: ext = (op == MEMOP_H) ? {{16{half[15]}}, half} : {16'b0, half};
      SZ_BYTE: ext = (op == MEMOP_B) ? {{24{byt[7]}}, byt} : {24'b0, byt};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage data-memory access unit with req/ack bus and timeout
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd_M,
  input  logic        MemWr_M,
  input  logic [2:0]  MemOp_M,
  input  logic [31:0] ext_result_M,
  input  logic [31:0] wdata_M,
  output logic [31:0] wd,
  output logic        stall_M,
  output logic        misalign,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rd_buf;
  logic [31:0]      ext_rdata;
  logic [1:0]       lane_q;
  logic [2:0]       op_q;
  logic [1:0]       lane;
  logic             acc, aligned, start, ack_hit, timeout_hit;

  assign lane        = ext_result_M[1:0];
  assign acc         = MemRd_M | MemWr_M;
  assign aligned     = is_aligned(MemOp_M, lane);
  assign start       = (state == ST_IDLE) && acc && aligned;
  assign ack_hit     = (state == ST_BUSY) && dm_ack;
  assign timeout_hit = (state == ST_BUSY) && !dm_ack && (cnt == CNT_W'(TIMEOUT - 1));

  // Lane and op are captured at request time so extension does not depend on the frozen pipeline.
  load_extender u_ext (
    .rdata (dm_rdata),
    .lane  (lane_q),
    .op    (op_q),
    .ext   (ext_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_BUSY;
      ST_BUSY: if (ack_hit || timeout_hit) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_M = 1'b0;
    wd      = ext_result_M;
    case (state)
      ST_IDLE: stall_M = start;
      ST_BUSY: stall_M = 1'b1;
      ST_DONE: wd = MemRd_M ? rd_buf : ext_result_M;
      default: stall_M = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_be    <= 4'b0;
      dm_addr  <= 32'b0;
      dm_wdata <= 32'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      rd_buf   <= 32'b0;
      cnt      <= '0;
      lane_q   <= 2'b0;
      op_q     <= 3'b0;
    end else begin
      misalign <= (state == ST_IDLE) && acc && !aligned;
      bus_err  <= timeout_hit;
      if (start) begin
        dm_req   <= 1'b1;
        dm_we    <= MemWr_M;
        dm_be    <= byte_en(MemOp_M, lane);
        dm_addr  <= {ext_result_M[31:2], 2'b00};
        dm_wdata <= lane_data(MemOp_M, wdata_M);
        lane_q   <= lane;
        op_q     <= MemOp_M;
        cnt      <= '0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + 1'b1;
        if (ack_hit) begin
          dm_req <= 1'b0;
          rd_buf <= ext_rdata;
        end else if (timeout_hit) begin
          dm_req <= 1'b0;
          rd_buf <= 32'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRd_M, MemWr_M;
  logic [2:0]  MemOp_M;
  logic [31:0] ext_result_M, wdata_M;
  logic [31:0] wd;
  logic        stall_M, misalign, bus_err;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .MemRd_M(MemRd_M), .MemWr_M(MemWr_M), .MemOp_M(MemOp_M),
    .ext_result_M(ext_result_M), .wdata_M(wdata_M),
    .wd(wd), .stall_M(stall_M), .misalign(misalign), .bus_err(bus_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] wd;
    int          stall_len;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   mis_q[$];
  int   err_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic drv_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request, pulse or completed M cycle.
  int   stall_cnt = 0;
  logic prev_req = 1'b0, prev_mis = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    req_t r;
    wb_t  w;
    if (!rst) begin
      if (dm_req && !prev_req) begin
        if (req_q.size() == 0) check("unexpected_req", 1, 0);
        else begin
          r = req_q.pop_front();
          check("dm_we", {31'b0, dm_we}, {31'b0, r.we});
          check("dm_be", {28'b0, dm_be}, {28'b0, r.be});
          check("dm_addr", dm_addr, r.addr);
          check("dm_wdata", dm_wdata, r.wdata);
        end
      end
      if (misalign) begin
        check("misalign_width", {31'b0, prev_mis}, 0);
        if (mis_q.size() == 0) check("unexpected_misalign", 1, 0);
        else void'(mis_q.pop_front());
      end
      if (bus_err) begin
        check("bus_err_width", {31'b0, prev_err}, 0);
        if (err_q.size() == 0) check("unexpected_bus_err", 1, 0);
        else void'(err_q.pop_front());
      end
      if (drv_active) begin
        if (stall_M) stall_cnt++;
        else begin
          if (wb_q.size() == 0) check("unexpected_wb", 1, 0);
          else begin
            w = wb_q.pop_front();
            check("wd", wd, w.wd);
            check("stall_len", stall_cnt, w.stall_len);
          end
          stall_cnt = 0;
        end
      end else stall_cnt = 0;
    end
    prev_req = dm_req;
    prev_mis = misalign;
    prev_err = bus_err;
  end

  task automatic do_op(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int ack_dly, input logic [31:0] rdata,
                       input logic [31:0] exp_wd, input int exp_len,
                       input logic exp_req, input logic [3:0] exp_be,
                       input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic exp_mis, input logic exp_err);
    wb_t  w;
    req_t r;
    int   guard;
    w.wd = exp_wd;
    w.stall_len = exp_len;
    wb_q.push_back(w);
    if (exp_req) begin
      r.we = wr; r.be = exp_be; r.addr = exp_addr; r.wdata = exp_wdata;
      req_q.push_back(r);
    end
    if (exp_mis) mis_q.push_back(1);
    if (exp_err) err_q.push_back(1);
    MemRd_M = rd; MemWr_M = wr; MemOp_M = op; ext_result_M = addr; wdata_M = wdata;
    drv_active = 1'b1;
    if (exp_req) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (!dm_req && guard < 64);
      if (!dm_req) check("req_wait_expired", 0, 1);
      if (ack_dly >= 0) begin
        repeat (ack_dly) @(negedge clk);
        dm_rdata = rdata;
        dm_ack = 1'b1;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        dm_rdata = 32'b0;
      end
    end
    guard = 0;
    do begin @(negedge clk); guard++; end while (stall_M && guard < 64);
    if (stall_M) check("stall_wait_expired", 1, 0);
    @(posedge clk); #1;
    MemRd_M = 1'b0; MemWr_M = 1'b0; MemOp_M = 3'b0; ext_result_M = 32'b0; wdata_M = 32'b0;
    drv_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int   guard;
    rst = 1'b1; MemRd_M = 1'b0; MemWr_M = 1'b0; MemOp_M = 3'b0;
    ext_result_M = 32'h1234; wdata_M = 32'b0; dm_rdata = 32'b0; dm_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_dm_req", {31'b0, dm_req}, 0);
    check("rst_dm_we", {31'b0, dm_we}, 0);
    check("rst_dm_be", {28'b0, dm_be}, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    check("rst_misalign", {31'b0, misalign}, 0);
    check("rst_bus_err", {31'b0, bus_err}, 0);
    check("rst_stall", {31'b0, stall_M}, 0);
    check("rst_wd", wd, 32'h1234);
    @(posedge clk); #1;

    //     rd wr op         addr          wdata          dly rdata          exp_wd         len req be       addr          wdata          mis err
    do_op(0, 0, MEMOP_W,  32'h0000_0055, 32'h0,         -1, 32'h0,         32'h0000_0055, 0,  0, 4'h0,    32'h0,         32'h0,         0, 0);
    do_op(1, 0, MEMOP_W,  32'h0000_0100, 32'h0,          0, 32'hDEADBEEF,  32'hDEADBEEF,  2,  1, 4'b1111, 32'h0000_0100, 32'h0,         0, 0);
    do_op(1, 0, MEMOP_B,  32'h0000_0103, 32'h0,          0, 32'h80112233,  32'hFFFFFF80,  2,  1, 4'b1000, 32'h0000_0100, 32'h0,         0, 0);
    do_op(1, 0, MEMOP_BU, 32'h0000_0103, 32'h0,          0, 32'h80112233,  32'h00000080,  2,  1, 4'b1000, 32'h0000_0100, 32'h0,         0, 0);
    do_op(0, 1, MEMOP_H,  32'h0000_0102, 32'hAAAA1234,   0, 32'h0,         32'h0000_0102, 2,  1, 4'b1100, 32'h0000_0100, 32'h12341234,  0, 0);
    do_op(1, 0, MEMOP_H,  32'h0000_0102, 32'h0,          1, 32'h80112233,  32'hFFFF8011,  3,  1, 4'b1100, 32'h0000_0100, 32'h0,         0, 0);
    do_op(1, 0, MEMOP_HU, 32'h0000_0100, 32'h0,          2, 32'h1234F00D,  32'h0000F00D,  4,  1, 4'b0011, 32'h0000_0100, 32'h0,         0, 0);
    do_op(0, 1, MEMOP_B,  32'h0000_0101, 32'h000000A5,   0, 32'h0,         32'h0000_0101, 2,  1, 4'b0010, 32'h0000_0100, 32'hA5A5A5A5,  0, 0);
    do_op(1, 0, 3'b111,   32'h0000_0104, 32'h0,          0, 32'h01020304,  32'h01020304,  2,  1, 4'b1111, 32'h0000_0104, 32'h0,         0, 0);
    do_op(1, 0, MEMOP_W,  32'h0000_0102, 32'h0,         -1, 32'h0,         32'h0000_0102, 0,  0, 4'h0,    32'h0,         32'h0,         1, 0);
    do_op(1, 0, MEMOP_H,  32'h0000_0101, 32'h0,         -1, 32'h0,         32'h0000_0101, 0,  0, 4'h0,    32'h0,         32'h0,         1, 0);
    do_op(1, 0, MEMOP_W,  32'h0000_0200, 32'h0,         -1, 32'h0,         32'h0,         17, 1, 4'b1111, 32'h0000_0200, 32'h0,         0, 1);
    do_op(0, 1, MEMOP_W,  32'h0000_0010, 32'hCAFEF00D,   0, 32'h0,         32'h0000_0010, 2,  1, 4'b1111, 32'h0000_0010, 32'hCAFEF00D,  0, 0);

    // Reset while BUSY; the late ack must not revive the transaction.
    r.we = 1'b0; r.be = 4'b1111; r.addr = 32'h200; r.wdata = 32'h0;
    req_q.push_back(r);
    MemRd_M = 1'b1; MemOp_M = MEMOP_W; ext_result_M = 32'h200;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!dm_req && guard < 64);
    if (!dm_req) check("rst_busy_req_wait_expired", 0, 1);
    @(posedge clk); #1;
    rst = 1'b1; MemRd_M = 1'b0; ext_result_M = 32'h300;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy_dm_req", {31'b0, dm_req}, 0);
    check("rst_busy_stall", {31'b0, stall_M}, 0);
    check("rst_busy_wd", wd, 32'h300);
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    @(negedge clk);
    check("late_ack_dm_req", {31'b0, dm_req}, 0);
    check("late_ack_stall", {31'b0, stall_M}, 0);
    check("late_ack_wd", wd, 32'h300);
    check("late_ack_bus_err", {31'b0, bus_err}, 0);
    repeat (3) @(posedge clk);
    #1;

    check("req_q_left", req_q.size(), 0);
    check("wb_q_left", wb_q.size(), 0);
    check("mis_q_left", mis_q.size(), 0);
    check("err_q_left", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
